// File: rtl/sched_pkg.sv
// Shared types and constants for the round-robin program scheduler.
// State codes are fixed values so debug tooling can decode them directly.
package sched_pkg;

  localparam int DEF_NUM_PROGS = 4;
  localparam int DEF_QW        = 16;

  localparam logic [2:0] ST_RUN     = 3'd0;
  localparam logic [2:0] ST_SAVE    = 3'd1;
  localparam logic [2:0] ST_SELECT  = 3'd2;
  localparam logic [2:0] ST_RESTORE = 3'd3;
  localparam logic [2:0] ST_HALTED  = 3'd4;

  typedef enum logic [2:0] {
    RUN     = ST_RUN,
    SAVE    = ST_SAVE,
    SELECT  = ST_SELECT,
    RESTORE = ST_RESTORE,
    HALTED  = ST_HALTED
  } sched_state_t;

  // Winning RUN-state event, lower code = higher priority.
  localparam logic [2:0] EV_NONE   = 3'd0;
  localparam logic [2:0] EV_END    = 3'd1;
  localparam logic [2:0] EV_CHANGE = 3'd2;
  localparam logic [2:0] EV_NEXT   = 3'd3;
  localparam logic [2:0] EV_EXPIRE = 3'd4;

endpackage

// File: rtl/program_scheduler_if.sv
// OS strobes, context-store handshake and status between the control unit and the scheduler.
// ctx_save/ctx_restore act as valid; ctx_done is the single-cycle completion acknowledge.
interface program_scheduler_if
  import sched_pkg::*;
#(
  parameter int NUM_PROGS = DEF_NUM_PROGS,
  parameter int QW        = DEF_QW,
  parameter int PID_W     = $clog2(NUM_PROGS)
);
  logic                 next_program;
  logic                 end_program;
  logic                 def_quantum;
  logic                 change_program;
  logic [QW-1:0]        quantum_val;
  logic [PID_W-1:0]     target_pid;
  logic                 instr_retire;
  logic                 prog_load;
  logic [PID_W-1:0]     load_pid;
  logic                 ctx_done;
  logic                 ctx_save;
  logic                 ctx_restore;
  logic [PID_W-1:0]     ctx_pid;
  logic [PID_W-1:0]     cur_pid;
  logic                 pc_hold;
  logic                 all_done;
  logic [NUM_PROGS-1:0] active_mask;
  sched_state_t         dbg_state;

  modport master (
    output next_program, end_program, def_quantum, change_program, quantum_val,
           target_pid, instr_retire, prog_load, load_pid, ctx_done,
    input  ctx_save, ctx_restore, ctx_pid, cur_pid, pc_hold, all_done, active_mask,
           dbg_state
  );

  modport slave (
    input  next_program, end_program, def_quantum, change_program, quantum_val,
           target_pid, instr_retire, prog_load, load_pid, ctx_done,
    output ctx_save, ctx_restore, ctx_pid, cur_pid, pc_hold, all_done, active_mask,
           dbg_state
  );
endinterface

// File: rtl/program_scheduler_rr_picker.sv
// Finds the first active slot after i_cur_pid, wrapping; i_cur_pid itself is the last candidate.
module rr_picker #(
  parameter int NUM_PROGS = 4,
  parameter int PID_W     = $clog2(NUM_PROGS)
) (
  input  logic [NUM_PROGS-1:0] i_active_mask,
  input  logic [PID_W-1:0]     i_cur_pid,
  output logic                 o_valid,
  output logic [PID_W-1:0]     o_pid
);
  logic [PID_W-1:0] w_cand;

  // Scan farthest to nearest so the nearest active slot overwrites the result.
  always_comb begin
    o_valid = 1'b0;
    o_pid   = i_cur_pid;
    w_cand  = '0;
    for (int k = NUM_PROGS; k >= 1; k--) begin
      w_cand = i_cur_pid + PID_W'(k);
      if (i_active_mask[w_cand]) begin
        o_valid = 1'b1;
        o_pid   = w_cand;
      end
    end
  end
endmodule

// File: rtl/program_scheduler.sv
// Round-robin preemptive scheduler: quantum counting, OS strobe handling and
// context save/restore sequencing with the PC frozen for the whole switch.
module program_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_PROGS = DEF_NUM_PROGS,
  parameter int QW        = DEF_QW,
  parameter int PID_W     = $clog2(NUM_PROGS)
) (
  input logic clk,
  input logic reset_n,
  program_scheduler_if.slave bus
);
  logic [2:0]           r_state;
  logic [PID_W-1:0]     r_cur_pid;
  logic [NUM_PROGS-1:0] r_mask;
  logic [QW-1:0]        r_quantum;
  logic [QW-1:0]        r_qcount;
  logic                 r_tgt_valid;
  logic [PID_W-1:0]     r_tgt_pid;

  logic                 w_change_ok;
  logic                 w_expire;
  logic [2:0]           w_event;
  logic                 w_pick_valid;
  logic [PID_W-1:0]     w_pick_pid;

  assign w_change_ok = bus.change_program && (bus.target_pid != r_cur_pid) &&
                       r_mask[bus.target_pid];
  assign w_expire    = (r_quantum != '0) && bus.instr_retire && (r_qcount == QW'(1));

  always_comb begin
    w_event = EV_NONE;
    if (bus.end_program)       w_event = EV_END;
    else if (w_change_ok)      w_event = EV_CHANGE;
    else if (bus.next_program) w_event = EV_NEXT;
    else if (w_expire)         w_event = EV_EXPIRE;
  end

  rr_picker #(.NUM_PROGS(NUM_PROGS), .PID_W(PID_W)) u_picker (
    .i_active_mask (r_mask),
    .i_cur_pid     (r_cur_pid),
    .o_valid       (w_pick_valid),
    .o_pid         (w_pick_pid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_RUN;
      r_cur_pid   <= '0;
      r_mask      <= NUM_PROGS'(1);
      r_quantum   <= '0;
      r_qcount    <= '0;
      r_tgt_valid <= 1'b0;
      r_tgt_pid   <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.instr_retire && (r_quantum != '0) && (r_qcount != '0))
            r_qcount <= r_qcount - QW'(1);
          case (w_event)
            EV_END: begin
              r_mask[r_cur_pid] <= 1'b0;
              r_state           <= ST_SELECT;
            end
            EV_CHANGE: begin
              r_tgt_valid <= 1'b1;
              r_tgt_pid   <= bus.target_pid;
              r_state     <= ST_SAVE;
            end
            EV_NEXT, EV_EXPIRE: r_state <= ST_SAVE;
            default: ;
          endcase
        end
        ST_SAVE: if (bus.ctx_done) r_state <= ST_SELECT;
        ST_SELECT: begin
          if (r_tgt_valid) begin
            r_cur_pid   <= r_tgt_pid;
            r_tgt_valid <= 1'b0;
            r_state     <= ST_RESTORE;
          end else if (!w_pick_valid) begin
            r_state <= ST_HALTED;
          end else if (w_pick_pid == r_cur_pid) begin
            // Sole survivor after a yield: its context never left, so no restore.
            r_qcount <= r_quantum;
            r_state  <= ST_RUN;
          end else begin
            r_cur_pid <= w_pick_pid;
            r_state   <= ST_RESTORE;
          end
        end
        ST_RESTORE: begin
          if (bus.ctx_done) begin
            r_qcount <= r_quantum;
            r_state  <= ST_RUN;
          end
        end
        ST_HALTED: if (bus.prog_load) r_state <= ST_SELECT;
        default: r_state <= ST_RUN;
      endcase

      if (bus.def_quantum) begin
        r_quantum <= bus.quantum_val;
        if (r_state == ST_RUN) r_qcount <= bus.quantum_val;
      end
      // Placed after the end_program clear so a same-cycle reload of that slot wins.
      if (bus.prog_load) r_mask[bus.load_pid] <= 1'b1;
    end
  end

  assign bus.ctx_save    = (r_state == ST_SAVE);
  assign bus.ctx_restore = (r_state == ST_RESTORE);
  assign bus.ctx_pid     = (bus.ctx_save || bus.ctx_restore) ? r_cur_pid : '0;
  assign bus.cur_pid     = r_cur_pid;
  assign bus.pc_hold     = (r_state != ST_RUN);
  assign bus.all_done    = (r_state == ST_HALTED);
  assign bus.active_mask = r_mask;
  assign bus.dbg_state   = sched_state_t'(r_state);
endmodule

// File: tb/tb_program_scheduler.sv
// Directed bench for program_scheduler: expected ctx requests queued at stimulus time,
// popped by a negedge monitor; status outputs checked directly against hand-computed values.
module tb_program_scheduler;
  import sched_pkg::*;

  localparam int NP = 4;
  localparam int QW = 16;
  localparam int PW = 2;
  localparam int W  = PW + 2;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  logic [W-1:0] exp_q[$];
  logic         prev_req;

  program_scheduler_if #(.NUM_PROGS(NP), .QW(QW)) bus ();

  program_scheduler #(.NUM_PROGS(NP), .QW(QW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] req_save(input int pid);
    return {1'b1, 1'b0, PW'(pid)};
  endfunction

  function automatic logic [W-1:0] req_rest(input int pid);
    return {1'b0, 1'b1, PW'(pid)};
  endfunction

  // Monitor: every new ctx request must match the head of the expected queue.
  always @(negedge clk) begin
    logic         req;
    logic [W-1:0] got;
    req = bus.ctx_save || bus.ctx_restore;
    if (reset_n && req && !prev_req) begin
      got = {bus.ctx_save, bus.ctx_restore, bus.ctx_pid};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL ctx_req: actual=%0h required=none (unexpected request)", got);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL ctx_req: actual={save,restore,pid}=%0h required=%0h", got, e);
        end
      end
    end
    prev_req = reset_n ? req : 1'b0;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input bit nx, input bit en, input bit ch, input bit dq,
                        input bit ld, input int pid, input int qv);
    bus.next_program   = nx;
    bus.end_program    = en;
    bus.change_program = ch;
    bus.def_quantum    = dq;
    bus.prog_load      = ld;
    bus.target_pid     = PW'(pid);
    bus.load_pid       = PW'(pid);
    bus.quantum_val    = QW'(qv);
    cyc();
    bus.next_program   = 1'b0;
    bus.end_program    = 1'b0;
    bus.change_program = 1'b0;
    bus.def_quantum    = 1'b0;
    bus.prog_load      = 1'b0;
  endtask

  // Wait (bounded) for a pending save/restore, then acknowledge it for one cycle.
  task automatic serve(input string what);
    int n;
    n = 0;
    while (!(bus.ctx_save || bus.ctx_restore) && n < 20) begin
      cyc();
      n++;
    end
    if (n == 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: actual=no ctx request in 20 cycles required=request", what);
    end else begin
      bus.ctx_done = 1'b1;
      cyc();
      bus.ctx_done = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hold_seen;
    n_checks = 0;
    n_fail   = 0;
    prev_req = 1'b0;
    reset_n  = 1'b0;
    bus.next_program = 0; bus.end_program = 0; bus.def_quantum = 0;
    bus.change_program = 0; bus.quantum_val = '0; bus.target_pid = '0;
    bus.instr_retire = 0; bus.prog_load = 0; bus.load_pid = '0; bus.ctx_done = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(bus.dbg_state), 32'(ST_RUN));
    check("rst_cur_pid", 32'(bus.cur_pid), 0);
    check("rst_mask", 32'(bus.active_mask), 32'h1);
    check("rst_pc_hold", 32'(bus.pc_hold), 0);
    check("rst_all_done", 32'(bus.all_done), 0);
    check("rst_ctx", 32'({bus.ctx_save, bus.ctx_restore, bus.ctx_pid}), 0);
    reset_n = 1'b1;
    cyc();

    // Quantum expiry after 3 retires: save 0, restore 1.
    strobe(0, 0, 0, 0, 1, 1, 0);
    strobe(0, 0, 0, 0, 1, 2, 0);
    strobe(0, 0, 0, 1, 0, 0, 3);
    check("mask_loaded", 32'(bus.active_mask), 32'h7);
    exp_q.push_back(req_save(0));
    exp_q.push_back(req_rest(1));
    bus.instr_retire = 1'b1;
    repeat (3) cyc();
    bus.instr_retire = 1'b0;
    check("expire_pc_hold", 32'(bus.pc_hold), 1);
    serve("expire_save");
    serve("expire_restore");
    check("expire_cur_pid", 32'(bus.cur_pid), 1);
    check("expire_pc_hold_low", 32'(bus.pc_hold), 0);

    // Yield 1 -> 2, then yield 2 -> 0 with wrap-around.
    exp_q.push_back(req_save(1));
    exp_q.push_back(req_rest(2));
    strobe(1, 0, 0, 0, 0, 0, 0);
    serve("y12_save");
    serve("y12_restore");
    exp_q.push_back(req_save(2));
    exp_q.push_back(req_rest(0));
    strobe(1, 0, 0, 0, 0, 0, 0);
    serve("wrap_save");
    serve("wrap_restore");
    check("wrap_cur_pid", 32'(bus.cur_pid), 0);

    // Build mask 0011 with cur_pid 1.
    exp_q.push_back(req_save(0));
    exp_q.push_back(req_rest(1));
    strobe(1, 0, 0, 0, 0, 0, 0);
    serve("s3a_save");
    serve("s3a_restore");
    exp_q.push_back(req_save(1));
    exp_q.push_back(req_rest(2));
    strobe(1, 0, 0, 0, 0, 0, 0);
    serve("s3b_save");
    serve("s3b_restore");
    exp_q.push_back(req_rest(0));
    strobe(0, 1, 0, 0, 0, 0, 0);
    serve("end2_restore");
    check("end2_mask", 32'(bus.active_mask), 32'h3);
    exp_q.push_back(req_save(0));
    exp_q.push_back(req_rest(1));
    strobe(1, 0, 0, 0, 0, 0, 0);
    serve("s3c_save");
    serve("s3c_restore");
    check("s3_cur_pid", 32'(bus.cur_pid), 1);

    // end_program beats next_program: no save, straight to restore of 0.
    exp_q.push_back(req_rest(0));
    strobe(1, 1, 0, 0, 0, 0, 0);
    check("endnext_mask", 32'(bus.active_mask), 32'h1);
    check("endnext_state", 32'(bus.dbg_state), 32'(ST_SELECT));
    serve("endnext_restore");
    check("endnext_cur_pid", 32'(bus.cur_pid), 0);

    // change_program to an inactive slot is ignored; after loading it, it switches.
    strobe(0, 0, 1, 0, 0, 3, 0);
    check("chg_inactive_pc_hold", 32'(bus.pc_hold), 0);
    check("chg_inactive_state", 32'(bus.dbg_state), 32'(ST_RUN));
    strobe(0, 0, 0, 0, 1, 3, 0);
    exp_q.push_back(req_save(0));
    exp_q.push_back(req_rest(3));
    strobe(0, 0, 1, 0, 0, 3, 0);
    serve("chg_save");
    serve("chg_restore");
    check("chg_cur_pid", 32'(bus.cur_pid), 3);
    check("chg_mask", 32'(bus.active_mask), 32'h9);

    // Finish 3, then 0: nothing left -> HALTED.
    exp_q.push_back(req_rest(0));
    strobe(0, 1, 0, 0, 0, 0, 0);
    serve("end3_restore");
    strobe(0, 1, 0, 0, 0, 0, 0);
    cyc();
    check("halt_all_done", 32'(bus.all_done), 1);
    check("halt_pc_hold", 32'(bus.pc_hold), 1);
    check("halt_mask", 32'(bus.active_mask), 0);
    exp_q.push_back(req_rest(2));
    strobe(0, 0, 0, 0, 1, 2, 0);
    check("halt_load_state", 32'(bus.dbg_state), 32'(ST_SELECT));
    serve("halt_restore");
    check("halt_exit_all_done", 32'(bus.all_done), 0);
    check("halt_exit_cur_pid", 32'(bus.cur_pid), 2);

    // Sole survivor yields: save only, back to RUN without a restore.
    exp_q.push_back(req_save(2));
    strobe(1, 0, 0, 0, 0, 0, 0);
    serve("sole_save");
    cyc();
    check("sole_state", 32'(bus.dbg_state), 32'(ST_RUN));
    check("sole_cur_pid", 32'(bus.cur_pid), 2);

    // Asynchronous reset in the middle of a save.
    exp_q.push_back(req_save(2));
    strobe(1, 0, 0, 0, 0, 0, 0);
    check("midsave_ctx_save", 32'(bus.ctx_save), 1);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_ctx_save", 32'(bus.ctx_save), 0);
    check("arst_cur_pid", 32'(bus.cur_pid), 0);
    check("arst_mask", 32'(bus.active_mask), 32'h1);
    check("arst_pc_hold", 32'(bus.pc_hold), 0);
    cyc();
    reset_n = 1'b1;
    cyc();
    hold_seen = 0;
    bus.instr_retire = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (bus.pc_hold) hold_seen++;
    end
    bus.instr_retire = 1'b0;
    check("no_preempt_pc_hold", 32'(hold_seen), 0);
    repeat (3) cyc();
    check("exp_q_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/program_scheduler.md
Name: program_scheduler

Overview:
Round-robin preemptive scheduler sequencing the processor between resident programs. Consumes the OS control strobes decoded by the control unit (nextProgram, endProgram, defquantum, changeProgram), counts the per-program quantum in retired instructions, and drives the context save/restore handshake toward the context store. It also freezes the PC while a switch is in progress.

Parameters:
NUM_PROGS, 4, number of program slots (power of two, >=2)
QW, 16, quantum counter width in bits
PID_W, $clog2(NUM_PROGS), program id width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
next_program  in  1  voluntary yield strobe (1 cycle)
end_program  in  1  current program finished strobe
def_quantum  in  1  load quantum reload value strobe
change_program  in  1  switch to target_pid strobe
quantum_val  in  QW  reload value sampled on def_quantum
target_pid  in  PID_W  destination for change_program
instr_retire  in  1  one instruction completed this cycle
prog_load  in  1  mark slot load_pid active
load_pid  in  PID_W  slot being loaded
ctx_done  in  1  context store completed current save/restore
ctx_save  out  1  request save of ctx_pid
ctx_restore  out  1  request restore of ctx_pid
ctx_pid  out  PID_W  slot for current ctx request
cur_pid  out  PID_W  program currently running
pc_hold  out  1  freeze PC/fetch
all_done  out  1  no active programs remain
active_mask  out  NUM_PROGS  slot active bits

Behaviour:
- Clock clk, reset asynchronous active-low on reset_n; all state cleared immediately on reset_n=0, regardless of in-flight handshake.
- Reset values: state=RUN, cur_pid=0, active_mask=1 (slot 0 active), quantum_reload=0, qcount=0, ctx_save=0, ctx_restore=0, ctx_pid=0, pc_hold=0, all_done=0.
- States: RUN, SAVE, SELECT, RESTORE, HALTED.
- RUN: pc_hold=0. Events sampled only in RUN; priority end_program > change_program > next_program > quantum expiry. Lower-priority events in the same cycle are dropped.
  - end_program: clear active_mask[cur_pid]; go SELECT (no save).
  - change_program: if target_pid==cur_pid or target slot inactive, ignored. Otherwise latch target, go SAVE.
  - next_program: go SAVE; selection is round-robin.
  - Quantum: qcount decrements on instr_retire when quantum_reload!=0. If qcount==1 and instr_retire, expiry: go SAVE. quantum_reload==0 disables preemption.
- SAVE: ctx_save=1, ctx_pid=cur_pid, pc_hold=1; held until ctx_done; next cycle SELECT.
- SELECT (1 cycle, pc_hold=1):
  - If a latched target exists, choose it.
  - Otherwise choose the first active slot after cur_pid, wrapping modulo NUM_PROGS; cur_pid itself is the last candidate if still active.
  - If no slot is active: HALTED.
  - If the chosen slot equals cur_pid (sole survivor after yield): return to RUN directly, no restore.
  - Otherwise cur_pid<=choice, go RESTORE.
- RESTORE: ctx_restore=1, ctx_pid=cur_pid, pc_hold=1 until ctx_done; then RUN with qcount<=quantum_reload.
- HALTED: all_done=1, pc_hold=1. A prog_load sets the bit and moves to SELECT next cycle.
- def_quantum: in any state, quantum_reload<=quantum_val; qcount is also reloaded if in RUN. Takes effect the next cycle; a same-cycle expiry still fires.
- prog_load: accepted in any state; sets active_mask[load_pid]. Loading an already-active slot has no effect.
- ctx_done outside SAVE/RESTORE is ignored. ctx_save and ctx_restore are never asserted together.
- Latency: yield to first restored fetch = 1 (event) + save cycles + 1 SELECT + restore cycles.

Decomposition:
- Package sched_pkg: sched_state_t enum (RUN, SAVE, SELECT, RESTORE, HALTED), default NUM_PROGS/QW, priority-encoding constants.
- Sub-module rr_picker: combinational next-active-slot finder (inputs active_mask, cur_pid; outputs valid, pid) instanced once in program_scheduler.

Test Plan:
- Reset then prog_load pid1,pid2; quantum_val=3 with def_quantum; retire 3 instrs -> ctx_save pid0; after ctx_done, SELECT; ctx_restore pid1; cur_pid=1, pc_hold low after restore ctx_done.
- next_program from pid2 with mask 0111 -> save pid2, restore pid0 (wrap-around).
- end_program and next_program same cycle on pid1 (mask 0011) -> no ctx_save; mask 0001; restore pid0.
- change_program target_pid=3 (inactive) -> ignored, no pc_hold. Then load pid3 and change -> save cur, restore pid3.
- end_program on last active slot -> HALTED, all_done=1. prog_load pid2 -> SELECT, restore pid2, all_done=0.
- reset_n asserted mid-SAVE while ctx_save=1 -> outputs return to reset values immediately; quantum_reload=0 confirms no preemption afterwards over 100 retires.
